// File: rtl/cpu_pkg.sv
// Shared picoMIPS definitions: opcode map, ALU function select and the
// registered control word handed from decode to execute.
package cpu_pkg;

  localparam int I_W    = 16;
  localparam int OP_W   = 6;
  localparam int RA_W   = 3;
  localparam int IMM_W  = 8;
  localparam int IMM5_W = 5;

  localparam logic [OP_W-1:0] P_NOP                 = 6'h00;
  localparam logic [OP_W-1:0] P_ADDI                = 6'h01;
  localparam logic [OP_W-1:0] P_BRANCH_IF_SW8_CLEAR = 6'h02;
  localparam logic [OP_W-1:0] P_ADD                 = 6'h03;
  localparam logic [OP_W-1:0] P_OUTPUT              = 6'h04;
  localparam logic [OP_W-1:0] P_LOAD                = 6'h05;
  localparam logic [OP_W-1:0] P_MUL                 = 6'h06;
  localparam logic [OP_W-1:0] P_MUL_RR              = 6'h30;

  typedef enum logic [1:0] {
    ALU_PASS_A = 2'd0,
    ALU_ADD    = 2'd1,
    ALU_MUL    = 2'd2,
    ALU_PASS_B = 2'd3
  } aluFunc_t;

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [RA_W-1:0]  rd;
    logic [RA_W-1:0]  rs;
    logic [RA_W-1:0]  rt;
    logic [IMM_W-1:0] imm;
    logic [IMM_W-1:0] branch_target;
    aluFunc_t         alu_func;
    logic             reg_write;
    logic             branch_en;
    logic             pc_incr;
    logic             load;
    logic             out;
    logic             src_a_is_rs;
    logic             src_b_is_imm;
    logic             src_b_is_sw;
    logic             illegal;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '{
    opcode: '0, rd: '0, rs: '0, rt: '0, imm: '0, branch_target: '0,
    alu_func: ALU_PASS_A, reg_write: 1'b0, branch_en: 1'b0, pc_incr: 1'b1,
    load: 1'b0, out: 1'b0, src_a_is_rs: 1'b0, src_b_is_imm: 1'b0,
    src_b_is_sw: 1'b0, illegal: 1'b0
  };

  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return (op == P_MUL) || (op == P_MUL_RR);
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Pure combinational picoMIPS decoder: raw instruction plus SW8 in, control
// word out. Unknown opcodes come out as the NOP word with illegal set.
module decode_logic
  import cpu_pkg::*;
#(
  parameter int IMM5_WIDTH = IMM5_W
) (
  input  logic [I_W-1:0] instr,
  input  logic           sw8,
  output ctrl_word_t     ctrl
);

  logic [OP_W-1:0] op;
  assign op = instr[I_W-1 -: OP_W];

  always_comb begin
    ctrl        = CTRL_NOP;
    ctrl.opcode = op;
    case (op)
      P_NOP: ;
      P_ADD: begin
        ctrl.rd          = instr[12:10];
        ctrl.rs          = instr[9:7];
        ctrl.rt          = instr[6:4];
        ctrl.alu_func    = ALU_ADD;
        ctrl.reg_write   = 1'b1;
        ctrl.src_a_is_rs = 1'b1;
      end
      P_ADDI: begin
        ctrl.rd           = instr[10:8];
        ctrl.rs           = instr[10:8];
        ctrl.imm          = instr[7:0];
        ctrl.alu_func     = ALU_ADD;
        ctrl.reg_write    = 1'b1;
        ctrl.src_a_is_rs  = 1'b1;
        ctrl.src_b_is_imm = 1'b1;
      end
      P_OUTPUT: begin
        ctrl.rs          = instr[10:8];
        ctrl.alu_func    = ALU_PASS_A;
        ctrl.out         = 1'b1;
        ctrl.src_a_is_rs = 1'b1;
      end
      P_LOAD: begin
        ctrl.rd          = instr[6:4];
        ctrl.rs          = instr[11:9];
        ctrl.alu_func    = ALU_PASS_B;
        ctrl.load        = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.src_b_is_sw = 1'b1;
      end
      P_MUL: begin
        // Accumulating form: the source register is also the destination.
        ctrl.rs           = instr[7:5];
        ctrl.rd           = instr[7:5];
        ctrl.imm          = IMM_W'(instr[IMM5_WIDTH-1:0]);
        ctrl.alu_func     = ALU_MUL;
        ctrl.reg_write    = 1'b1;
        ctrl.src_a_is_rs  = 1'b1;
        ctrl.src_b_is_imm = 1'b1;
      end
      P_MUL_RR: begin
        ctrl.rd          = instr[9:7];
        ctrl.rs          = instr[6:4];
        ctrl.rt          = instr[3:1];
        ctrl.alu_func    = ALU_MUL;
        ctrl.reg_write   = 1'b1;
        ctrl.src_a_is_rs = 1'b1;
      end
      P_BRANCH_IF_SW8_CLEAR: begin
        ctrl.branch_target = instr[7:0];
        ctrl.branch_en     = !sw8;
        ctrl.pc_incr       = sw8;
      end
      default: begin
        ctrl         = CTRL_NOP;
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: skid buffer in front of a decoded output register,
// with MUL issue hold, taken-branch squash and flush.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int I_WIDTH        = I_W,
  parameter int OPCODE_WIDTH   = OP_W,
  parameter int REG_ADDR_WIDTH = RA_W,
  parameter int IMM_WIDTH      = IMM_W,
  parameter int IMM5_WIDTH     = IMM5_W,
  parameter int BUF_DEPTH      = 2,
  parameter int MUL_CYCLES     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [I_WIDTH-1:0]        instr,
  input  logic                      SW8,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPCODE_WIDTH-1:0]   opcode,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [REG_ADDR_WIDTH-1:0] rs,
  output logic [REG_ADDR_WIDTH-1:0] rt,
  output logic [IMM_WIDTH-1:0]      imm,
  output logic [IMM_WIDTH-1:0]      branch_target,
  output aluFunc_t                  ALUfunc,
  output logic                      reg_write,
  output logic                      branch_en,
  output logic                      PCincr,
  output logic                      load,
  output logic                      out,
  output logic                      aluSrcA_is_Rs,
  output logic                      aluSrcB_is_Imm,
  output logic                      aluSrcB_is_SW,
  output logic                      illegal,
  output logic                      busy
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int HW = $clog2(MUL_CYCLES + 1);

  logic [I_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count, pop_n;
  logic [HW-1:0]      hold_cnt;
  logic               out_valid_q;
  ctrl_word_t         ctrl_q, dec;
  logic [I_WIDTH-1:0] ld_instr;
  logic empty, full, in_fire, drain, mul_drain, load_en, ld_fire, bypass, taken, push;

  assign empty     = (count == '0);
  assign full      = (count == CW'(BUF_DEPTH));
  assign in_ready  = !full && (hold_cnt == '0);
  assign in_fire   = in_valid && in_ready;
  assign drain     = out_valid_q && out_ready;
  assign mul_drain = drain && is_mul(ctrl_q.opcode) && (MUL_CYCLES > 1);

  // The last hold cycle may already refill the output so the next word
  // appears as soon as the hold ends.
  assign load_en   = (hold_cnt <= HW'(1)) && (!out_valid_q || out_ready) && !mul_drain;
  assign bypass    = load_en && empty && in_fire;
  assign ld_fire   = load_en && (!empty || in_fire);
  assign ld_instr  = empty ? instr : mem[rd_ptr];

  decode_logic #(.IMM5_WIDTH(IMM5_WIDTH)) u_dec (
    .instr (ld_instr),
    .sw8   (SW8),
    .ctrl  (dec)
  );

  assign taken = ld_fire && dec.branch_en;

  // A taken branch kills the entry behind it and anything arriving this cycle.
  always_comb begin
    push  = in_fire && !bypass && !taken;
    pop_n = '0;
    if (ld_fire && !empty)
      pop_n = (taken && count >= CW'(2)) ? CW'(2) : CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= instr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      hold_cnt    <= '0;
      ctrl_q      <= CTRL_NOP;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + CW'(push) - pop_n;
      if (ld_fire) begin
        ctrl_q      <= dec;
        out_valid_q <= 1'b1;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
      if (mul_drain)            hold_cnt <= HW'(MUL_CYCLES - 1);
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - HW'(1);
    end
  end

  assign out_valid      = out_valid_q;
  assign opcode         = ctrl_q.opcode;
  assign rd             = ctrl_q.rd;
  assign rs             = ctrl_q.rs;
  assign rt             = ctrl_q.rt;
  assign imm            = ctrl_q.imm;
  assign branch_target  = ctrl_q.branch_target;
  assign ALUfunc        = ctrl_q.alu_func;
  assign reg_write      = ctrl_q.reg_write;
  assign branch_en      = ctrl_q.branch_en;
  assign PCincr         = ctrl_q.pc_incr;
  assign load           = ctrl_q.load;
  assign out            = ctrl_q.out;
  assign aluSrcA_is_Rs  = ctrl_q.src_a_is_rs;
  assign aluSrcB_is_Imm = ctrl_q.src_b_is_imm;
  assign aluSrcB_is_SW  = ctrl_q.src_b_is_sw;
  assign illegal        = ctrl_q.illegal;
  assign busy           = !empty || (hold_cnt != '0);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: handshake, ordering, branch squash,
// MUL hold, illegal opcodes, flush and reset.
module tb_decode_stage;
  import cpu_pkg::*;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, SW8 = 1'b0, flush = 1'b0;
  logic [15:0] instr = '0;
  logic out_valid, out_ready = 1'b0;
  logic [5:0] opcode;
  logic [2:0] rd, rs, rt;
  logic [7:0] imm, branch_target;
  aluFunc_t ALUfunc;
  logic reg_write, branch_en, PCincr, load, out;
  logic aluSrcA_is_Rs, aluSrcB_is_Imm, aluSrcB_is_SW, illegal, busy;

  int tests = 0;
  int fails = 0;

  decode_stage #(.BUF_DEPTH(2), .MUL_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .SW8(SW8), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
    .imm(imm), .branch_target(branch_target), .ALUfunc(ALUfunc),
    .reg_write(reg_write), .branch_en(branch_en), .PCincr(PCincr),
    .load(load), .out(out), .aluSrcA_is_Rs(aluSrcA_is_Rs),
    .aluSrcB_is_Imm(aluSrcB_is_Imm), .aluSrcB_is_SW(aluSrcB_is_SW),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic offer(input logic [15:0] i);
    in_valid = 1'b1;
    instr    = i;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    // reset state
    step(); step();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready",  32'(in_ready), 1);
    check("rst_busy",      32'(busy), 0);
    check("rst_pcincr",    32'(PCincr), 1);
    check("rst_alufunc",   32'(ALUfunc), 32'(ALU_PASS_A));
    check("rst_opcode",    32'(opcode), 0);
    check("rst_illegal",   32'(illegal), 0);
    reset = 1'b0;

    // 1: ADDI with one-cycle latency
    out_ready = 1'b1;
    offer(16'h048a);
    check("t1_valid",   32'(out_valid), 1);
    check("t1_opcode",  32'(opcode), 32'h01);
    check("t1_rd",      32'(rd), 4);
    check("t1_rs",      32'(rs), 4);
    check("t1_imm",     32'(imm), 32'h8a);
    check("t1_alu",     32'(ALUfunc), 32'(ALU_ADD));
    check("t1_regw",    32'(reg_write), 1);
    check("t1_srcbimm", 32'(aluSrcB_is_Imm), 1);
    step();
    check("t1_drained", 32'(out_valid), 0);

    // 2: back-pressure and ordering
    out_ready = 1'b0;
    offer(16'h0501);
    offer(16'h0602);
    check("t2_ready_mid", 32'(in_ready), 1);
    offer(16'h0703);
    check("t2_full_ready", 32'(in_ready), 0);
    in_valid = 1'b1; instr = 16'h0404;
    step();
    in_valid = 1'b0;
    check("t2_hold_imm", 32'(imm), 32'h01);
    check("t2_hold_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    step();
    check("t2_imm2", 32'(imm), 32'h02);
    check("t2_ready_rise", 32'(in_ready), 1);
    step();
    check("t2_imm3", 32'(imm), 32'h03);
    check("t2_valid3", 32'(out_valid), 1);
    step();
    check("t2_empty", 32'(out_valid), 0);

    // 3a: taken branch squashes the buffered entry behind it
    out_ready = 1'b0; SW8 = 1'b0;
    offer(16'h0501); offer(16'h0804); offer(16'h048a);
    out_ready = 1'b1;
    step();
    check("t3a_opcode", 32'(opcode), 32'h02);
    check("t3a_br_en",  32'(branch_en), 1);
    check("t3a_pcinc",  32'(PCincr), 0);
    check("t3a_target", 32'(branch_target), 32'h04);
    check("t3a_busy",   32'(busy), 0);
    step();
    check("t3a_squash", 32'(out_valid), 0);

    // 3b: not-taken branch lets the follower through
    out_ready = 1'b0; SW8 = 1'b1;
    offer(16'h0501); offer(16'h0804); offer(16'h048a);
    out_ready = 1'b1;
    step();
    check("t3b_br_en", 32'(branch_en), 0);
    check("t3b_pcinc", 32'(PCincr), 1);
    step();
    check("t3b_valid", 32'(out_valid), 1);
    check("t3b_imm",   32'(imm), 32'h8a);
    step();
    check("t3b_empty", 32'(out_valid), 0);

    // 3c: instruction accepted in the squash cycle is dropped
    out_ready = 1'b0; SW8 = 1'b0;
    offer(16'h0501); offer(16'h0804);
    out_ready = 1'b1;
    offer(16'h048a);
    check("t3c_br_en", 32'(branch_en), 1);
    check("t3c_busy",  32'(busy), 0);
    step();
    check("t3c_squash", 32'(out_valid), 0);

    // 4: MUL_RR hold of MUL_CYCLES-1 cycles
    offer(16'hc2b8);
    check("t4_rd",  32'(rd), 5);
    check("t4_rs",  32'(rs), 3);
    check("t4_rt",  32'(rt), 4);
    check("t4_alu", 32'(ALUfunc), 32'(ALU_MUL));
    check("t4_regw", 32'(reg_write), 1);
    offer(16'h048a);
    check("t4_h1_valid", 32'(out_valid), 0);
    check("t4_h1_ready", 32'(in_ready), 0);
    step();
    check("t4_h2_valid", 32'(out_valid), 0);
    check("t4_h2_ready", 32'(in_ready), 0);
    step();
    check("t4_after_valid", 32'(out_valid), 1);
    check("t4_after_imm",   32'(imm), 32'h8a);
    check("t4_after_ready", 32'(in_ready), 1);
    step();

    // 5: illegal opcode, then normal decode
    offer(16'hfc00);
    check("t5_illegal", 32'(illegal), 1);
    check("t5_regw",    32'(reg_write), 0);
    check("t5_alu",     32'(ALUfunc), 32'(ALU_PASS_A));
    check("t5_flags",   {29'd0, load, out, branch_en}, 0);
    offer(16'h1040);
    check("t5_next_illegal", 32'(illegal), 0);
    check("t5_next_out",     32'(out), 1);
    step();

    // 6a: flush with full buffer and hold active
    out_ready = 1'b0;
    offer(16'hc2b8); offer(16'h0501); offer(16'h0602);
    out_ready = 1'b1;
    step();
    check("t6a_busy",  32'(busy), 1);
    check("t6a_ready", 32'(in_ready), 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6a_valid", 32'(out_valid), 0);
    check("t6a_ready_after", 32'(in_ready), 1);
    check("t6a_busy_after",  32'(busy), 0);
    offer(16'h1040);
    check("t6a_out", 32'(out), 1);
    check("t6a_rs",  32'(rs), 0);
    step();

    // 6b: reset with full buffer and hold active
    out_ready = 1'b0;
    offer(16'hc2b8); offer(16'h0501); offer(16'h0602);
    out_ready = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6b_valid", 32'(out_valid), 0);
    check("t6b_ready", 32'(in_ready), 1);
    offer(16'h1040);
    check("t6b_out", 32'(out), 1);
    check("t6b_rs",  32'(rs), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
